comb_sched: RTL
===============

COMB_SCHED -- requirements
Module: comb_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the datapath (2..8).
REQ-002 SHALL have parameter NX, default 8, operand and result width in bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous to CLK, active-high.
REQ-005 SHALL have port REQ_VALID  input  NREQ  bit i high: requester i presents an operand pair.
REQ-006 SHALL have port REQ_READY  output  NREQ  bit i high: requester i is accepted this cycle (one-hot or zero).
REQ-007 SHALL have port REQ_A  input  NREQ*NX  operand A, requester i at bits [i*NX +: NX].
REQ-008 SHALL have port REQ_B  input  NREQ*NX  operand B, same packing as REQ_A.
REQ-009 SHALL have port RES_VALID  output  1  result register holds a valid result.
REQ-010 SHALL have port RES_READY  input  1  consumer accepts the result this cycle.
REQ-011 SHALL have port RES_ID  output  clog2(NREQ)  index of the requester that owns XOUT.
REQ-012 SHALL have port XOUT  output  NX  registered result.

Function
REQ-013 SHALL compute result = (A - NX'(7*B)) mod 2^NX; 7*B truncated to NX bits before subtraction, result truncated to NX bits, all unsigned.
REQ-014 SHALL implement a two-state FSM: EMPTY (RES_VALID=0) and FULL (RES_VALID=1).
REQ-015 SHALL define slot-free = EMPTY, or FULL and RES_READY=1 in the same cycle.
REQ-016 SHALL, when slot-free and any REQ_VALID bit is high, assert exactly one REQ_READY bit (the granted requester) combinationally in that cycle; otherwise all REQ_READY bits SHALL be 0.
REQ-017 SHALL never assert REQ_READY[i] while REQ_VALID[i]=0.
REQ-018 SHALL, on a grant edge, load XOUT with the granted result and RES_ID with the granted index, and enter or remain in FULL; latency request-accept to RES_VALID = 1 cycle.
REQ-019 SHALL, when FULL, RES_READY=1 and no REQ_VALID bit is high, go to EMPTY at the next edge.
REQ-020 SHALL, in FULL with RES_READY=0, hold XOUT, RES_ID and RES_VALID stable, and assert no REQ_READY bit.
REQ-021 SHALL sustain one result per cycle when RES_READY is held high and requests are continuously present.
REQ-022 SHALL, when FULL with RES_READY=0, sample no operands; requesters SHALL hold their operands until granted.

Reset
REQ-023 SHALL, when RST=1 at a rising edge, set FSM to EMPTY, RES_VALID=0, XOUT=0, RES_ID=0, and the priority pointer to NREQ-1 (requester 0 highest next).
REQ-024 SHALL, during the reset cycle, drive REQ_READY=0; a result held when reset is applied SHALL be discarded without handshake.
REQ-025 SHALL accept requests starting from the first edge after RST deasserts.

Configuration
REQ-026 SHALL, when macro COMB_SCHED_RR_EN is defined, use round-robin arbitration: the search starts at (last granted index + 1) mod NREQ; the pointer updates only on a grant.
REQ-027 SHALL, when COMB_SCHED_RR_EN is not defined, use fixed priority (lowest index wins) and omit the pointer register; reset behaviour is otherwise identical.

Verification
REQ-028 SHALL cover: after reset, req0 A=10,B=3 valid, RES_READY=1 -> REQ_READY=0001 same cycle; next cycle RES_VALID=1, XOUT=245, RES_ID=0.
REQ-029 SHALL cover: req1 A=100,B=40 -> XOUT=76 (7*40 truncated to 24); and A=255,B=0 -> XOUT=255.
REQ-030 SHALL cover: all four REQ_VALID high, RES_READY=1, with RR_EN -> grants 0,1,2,3,0 on consecutive cycles; without RR_EN -> grants 0,0,0 and so on.
REQ-031 SHALL cover: FULL with RES_READY=0 for 5 cycles -> XOUT/RES_ID stable, REQ_READY=0; RES_READY=1 -> pending request granted the same cycle, new result the next cycle.
REQ-032 SHALL cover: RST=1 while FULL with XOUT=76 -> next cycle RES_VALID=0, XOUT=0, RES_ID=0; RR pointer restarts at requester 0.
REQ-033 SHALL cover: FULL, RES_READY=1, no requests -> EMPTY next cycle, RES_VALID=0.

Source files
------------

// File: rtl/comb_sched.sv
// Shared (A - 7*B) datapath for NREQ requesters with a one-entry result register.
// Arbitration is fixed priority by default; defining COMB_SCHED_RR_EN selects round-robin.
module comb_sched #(
  parameter int NREQ = 4,
  parameter int NX   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*NX-1:0]   REQ_A,
  input  logic [NREQ*NX-1:0]   REQ_B,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [$clog2(NREQ)-1:0] RES_ID,
  output logic [NX-1:0]        XOUT
);

  // state | meaning
  // EMPTY | result register holds nothing, RES_VALID low
  // FULL  | result register holds a result awaiting RES_READY

  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_idx;
  logic            found;
  logic            slot_free;
  logic            grant;
  logic [NX-1:0]   a_sel, b_sel, b7, res;
  logic [IW-1:0]   id_q;
  logic [NX-1:0]   xout_q;

`ifdef COMB_SCHED_RR_EN
  logic [IW-1:0]   ptr_q;
`endif

  // Rotating search; idx carries one extra bit so the wrap compare works for any NREQ.
  always_comb begin : arb
    logic [IW:0] start;
    logic [IW:0] idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
`ifdef COMB_SCHED_RR_EN
    start = {1'b0, ptr_q} + (IW+1)'(1);
`else
    start = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = start + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && REQ_VALID[idx[IW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[IW-1:0];
      end
    end
  end

  assign slot_free = (state_q == EMPTY) || RES_READY;
  assign grant     = slot_free && found && !RST;
  assign REQ_READY = grant ? (NREQ'(1) << gnt_idx) : '0;

  // 7*B as (B<<3)-B, both naturally truncated to NX bits.
  always_comb begin
    a_sel = REQ_A[gnt_idx*NX +: NX];
    b_sel = REQ_B[gnt_idx*NX +: NX];
    b7    = (b_sel << 3) - b_sel;
    res   = a_sel - b7;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grant)
      state_d = FULL;
    else if (state_q == FULL && RES_READY)
      state_d = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      xout_q <= '0;
      id_q   <= '0;
    end else if (grant) begin
      xout_q <= res;
      id_q   <= gnt_idx;
    end
  end

`ifdef COMB_SCHED_RR_EN
  // Reset to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge CLK) begin
    if (RST)        ptr_q <= IW'(NREQ-1);
    else if (grant) ptr_q <= gnt_idx;
  end
`endif

  assign RES_VALID = (state_q == FULL);
  assign RES_ID    = id_q;
  assign XOUT      = xout_q;

endmodule
